// File: rtl/id_hazard_scoreboard.sv
// RAW-hazard scoreboard for the ID stage: shadows the EX/ME/WB writeback destinations and
// derives the load-use stall, per-operand forward selects and a saturating stall counter.
module id_hazard_scoreboard #(
    parameter bit LOAD_FWD_ME = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             id_valid,
    input  logic             id_fire,
    input  logic [4:0]       id_dest,
    input  logic             id_gr_we,
    input  logic             id_is_load,
    input  logic [4:0]       id_rj,
    input  logic             id_rj_use,
    input  logic [4:0]       id_rkd,
    input  logic             id_rkd_use,
    input  logic             ex_fire,
    input  logic             me_fire,
    input  logic             wb_fire,
    input  logic             flush,
    output logic             id_stall,
    output logic [1:0]       fwd_rj_sel,
    output logic [1:0]       fwd_rkd_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             ex_v_q, ex_v_d, ex_ld_q, ex_ld_d;
    logic [4:0]       ex_dest_q, ex_dest_d;
    logic             me_v_q, me_v_d, me_ld_q, me_ld_d;
    logic [4:0]       me_dest_q, me_dest_d;
    logic             wb_v_q, wb_v_d, wb_ld_q, wb_ld_d;
    logic [4:0]       wb_dest_q, wb_dest_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [1:0]       rj_sel, rkd_sel;
    logic             rj_hz, rkd_hz, stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Youngest matching writer wins; r0 is hard-wired and never matches.
    function automatic logic [1:0] pick_src(
        input logic [4:0] r,  input logic use_r,
        input logic ev, input logic [4:0] ed,
        input logic mv, input logic [4:0] md,
        input logic wv, input logic [4:0] wd
    );
        logic ok;
        ok = use_r && (r != 5'd0);
        if (ok && ev && ed == r) return 2'd1;
        if (ok && mv && md == r) return 2'd2;
        if (ok && wv && wd == r) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic load_hazard(input logic [1:0] sel, input logic eld,
                                         input logic mld);
        return (sel == 2'd1 && eld) || (LOAD_FWD_ME == 1'b0 && sel == 2'd2 && mld);
    endfunction

    always_comb begin
        rj_sel  = pick_src(id_rj, id_rj_use, ex_v_q, ex_dest_q, me_v_q, me_dest_q,
                           wb_v_q, wb_dest_q);
        rkd_sel = pick_src(id_rkd, id_rkd_use, ex_v_q, ex_dest_q, me_v_q, me_dest_q,
                           wb_v_q, wb_dest_q);
        rj_hz   = load_hazard(rj_sel, ex_ld_q, me_ld_q);
        rkd_hz  = load_hazard(rkd_sel, ex_ld_q, me_ld_q);
        stall   = id_valid && (rj_hz || rkd_hz);
    end

    // A non-writing or flushed instruction still occupies EX as a bubble to keep slots aligned.
    always_comb begin
        ex_v_d    = ex_v_q;
        ex_dest_d = ex_dest_q;
        ex_ld_d   = ex_ld_q;
        me_v_d    = me_v_q;
        me_dest_d = me_dest_q;
        me_ld_d   = me_ld_q;
        wb_v_d    = wb_v_q;
        wb_dest_d = wb_dest_q;
        wb_ld_d   = wb_ld_q;

        if (id_fire) begin
            ex_v_d    = id_gr_we && !flush;
            ex_dest_d = id_dest;
            ex_ld_d   = id_is_load;
        end else if (ex_fire) begin
            ex_v_d = 1'b0;
        end

        if (ex_fire) begin
            me_v_d    = ex_v_q;
            me_dest_d = ex_dest_q;
            me_ld_d   = ex_ld_q;
        end else if (me_fire) begin
            me_v_d = 1'b0;
        end

        if (me_fire) begin
            wb_v_d    = me_v_q;
            wb_dest_d = me_dest_q;
            wb_ld_d   = me_ld_q;
        end else if (wb_fire) begin
            wb_v_d = 1'b0;
        end

        stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_v_q      <= 1'b0;
            ex_dest_q   <= 5'd0;
            ex_ld_q     <= 1'b0;
            me_v_q      <= 1'b0;
            me_dest_q   <= 5'd0;
            me_ld_q     <= 1'b0;
            wb_v_q      <= 1'b0;
            wb_dest_q   <= 5'd0;
            wb_ld_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_dest_q   <= ex_dest_d;
            ex_ld_q     <= ex_ld_d;
            me_v_q      <= me_v_d;
            me_dest_q   <= me_dest_d;
            me_ld_q     <= me_ld_d;
            wb_v_q      <= wb_v_d;
            wb_dest_q   <= wb_dest_d;
            wb_ld_q     <= wb_ld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign id_stall    = stall;
    assign fwd_rj_sel  = rj_sel;
    assign fwd_rkd_sel = rkd_sel;
    assign stall_cnt   = stall_cnt_q;

endmodule
